// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizing for the CDB arbiter.
// Holds the broadcast and ROB-completion packet layouts and the default
// requester/slot counts used as parameter defaults by cdb_arbiter.
package cdb_arbiter_pkg;

    // Functional-unit population feeding the CDB
    localparam int NUM_FU_ALU           = 3;
    localparam int NUM_FU_MULT          = 1;
    localparam int NUM_FU_LOAD          = 1;

    // Broadcast slots per cycle
    localparam int CDB_SZ               = 2;

    // Denied cycles before a requester is promoted to urgent
    localparam int CDB_ARB_STARVE_LIMIT = 4;

    // Field widths
    localparam int PRN_W                = 6;
    localparam int ROB_W                = 5;
    localparam int XLEN                 = 32;

    // Result broadcast to RS and PRF; dest_prn of 0 means "no broadcast"
    typedef struct packed {
        logic [PRN_W-1:0] dest_prn;
        logic [XLEN-1:0]  value;
    } CDB_PACKET;

    // Completion information for the ROB
    typedef struct packed {
        logic [ROB_W-1:0] robn;
        logic             executed;
        logic             branch_taken;
        logic [XLEN-1:0]  target_addr;
    } FU_ROB_PACKET;

    // Width of a counter that must hold 0..limit
    function automatic int cdb_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cdb_arbiter_prio_slot_select.sv
// Two-class priority encoder for CDB slot allocation.
// Slots are filled in order; each slot takes the lowest-index urgent
// requester still available, and only when no urgent requester remains does
// it fall back to the lowest-index valid one. Because urgent requesters are
// always preferred, all urgent winners occupy the low slots.
module prio_slot_select #(
    parameter int NUM_REQ = 5,
    parameter int SIZE    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] urgent,
    output logic [NUM_REQ-1:0] slot_sel [SIZE],
    output logic [NUM_REQ-1:0] grant
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Isolate the lowest set bit as a one-hot (zero when the input is zero)
    function automatic logic [NUM_REQ-1:0] lowest(input logic [NUM_REQ-1:0] x);
        return x & (~x + ONE);
    endfunction

    // Walk the slots, removing each winner from the candidate pool
    always_comb begin
        logic [NUM_REQ-1:0] avail;
        logic [NUM_REQ-1:0] urgent_avail;
        avail = valid;
        for (int k = 0; k < SIZE; k++) begin
            urgent_avail = avail & urgent;
            slot_sel[k]  = (|urgent_avail) ? lowest(urgent_avail) : lowest(avail);
            avail        = avail & ~slot_sel[k];
        end
        grant = valid & ~avail;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter.
// Grants up to SIZE completion requesters per cycle (fixed priority with
// starvation aging), returns the grant combinationally, and registers the
// granted packets onto the broadcast slots one cycle later.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD,
    parameter int SIZE         = CDB_SZ,
    parameter int STARVE_LIMIT = CDB_ARB_STARVE_LIMIT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic [NUM_REQ-1:0] req_valid,
    input  CDB_PACKET          req_cdb [NUM_REQ],
    input  FU_ROB_PACKET       req_rob [NUM_REQ],
    output logic [NUM_REQ-1:0] grant,
    output CDB_PACKET          cdb_output [SIZE],
    output FU_ROB_PACKET       fu_rob_packet [SIZE]
);

    localparam int              CNT_W   = cdb_cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam int              CDB_W   = $bits(CDB_PACKET);
    localparam int              ROB_PW  = $bits(FU_ROB_PACKET);

    logic [CNT_W-1:0]   starve_cnt_reg  [NUM_REQ];
    logic [CNT_W-1:0]   starve_cnt_next [NUM_REQ];
    logic [NUM_REQ-1:0] urgent;
    logic [NUM_REQ-1:0] sel_grant;
    logic [NUM_REQ-1:0] slot_sel [SIZE];
    CDB_PACKET          cdb_next [SIZE];
    FU_ROB_PACKET       rob_next [SIZE];

    genvar gi;

    // Urgency and saturating age update, one lane per requester
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign urgent[gi] = req_valid[gi] && (starve_cnt_reg[gi] == CNT_MAX);
            assign starve_cnt_next[gi] =
                (req_valid[gi] && !grant[gi])
                    ? ((starve_cnt_reg[gi] == CNT_MAX) ? CNT_MAX
                                                       : starve_cnt_reg[gi] + CNT_W'(1))
                    : '0;
        end
    endgenerate

    prio_slot_select #(
        .NUM_REQ (NUM_REQ),
        .SIZE    (SIZE)
    ) u_select (
        .valid    (req_valid),
        .urgent   (urgent),
        .slot_sel (slot_sel),
        .grant    (sel_grant)
    );

    // Nothing is accepted while the pipeline is being reset or flushed
    assign grant = (reset || squash) ? '0 : sel_grant;

    // AND-OR slot muxes; an empty slot naturally yields an all-zero packet
    always_comb begin
        for (int k = 0; k < SIZE; k++) begin
            cdb_next[k] = '0;
            rob_next[k] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cdb_next[k] = cdb_next[k] | (req_cdb[i] & {CDB_W{slot_sel[k][i]}});
                rob_next[k] = rob_next[k] | (req_rob[i] & {ROB_PW{slot_sel[k][i]}});
            end
        end
    end

    // Broadcast registers and age counters; reset and squash both clear
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            for (int k = 0; k < SIZE; k++) begin
                cdb_output[k]    <= '0;
                fu_rob_packet[k] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                starve_cnt_reg[i] <= '0;
            end
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                cdb_output[k]    <= cdb_next[k];
                fu_rob_packet[k] <= rob_next[k];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                starve_cnt_reg[i] <= starve_cnt_next[i];
            end
        end
    end

endmodule
